// File: rtl/registers_pkg.sv
// Shared widths, data type and clear value for the TinyCPU datapath registers.
package registers_pkg;
  localparam int DATA_W = 8;

  typedef logic [DATA_W-1:0] data_t;

  localparam data_t DEFAULT_RESET_VALUE = '0;
endpackage

// File: rtl/registers_reg_bit.sv
// One enabled storage bit with asynchronous active-low clear.
// The clear value is fixed per instance so the parent can assemble any reset pattern.
module reg_bit
  import registers_pkg::*;
#(
  parameter logic RESET_BIT = 1'b0
) (
  input  logic i_clk,
  input  logic i_clr_n,
  input  logic i_en,
  input  logic i_d,
  output logic o_q
);

  logic r_q;

  always_ff @(posedge i_clk or negedge i_clr_n) begin
    if (!i_clr_n) begin
      r_q <= RESET_BIT;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/registers.sv
// TinyCPU data register: captures H on a rising Clock edge when Enable is high.
// Clr (active-low) clears it to RESET_VALUE at once and overrides any load.
module registers
  import registers_pkg::*;
#(
  parameter int               WIDTH       = DATA_W,
  parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(DEFAULT_RESET_VALUE)
) (
  input  logic             Clock,
  input  logic             Clr,
  input  logic             Enable,
  input  logic [WIDTH-1:0] H,
  output logic [WIDTH-1:0] Hout
);

  logic [WIDTH-1:0] w_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    reg_bit #(
      .RESET_BIT (RESET_VALUE[i])
    ) u_bit (
      .i_clk   (Clock),
      .i_clr_n (Clr),
      .i_en    (Enable),
      .i_d     (H[i]),
      .o_q     (w_q[i])
    );
  end

  assign Hout = w_q;

`ifndef SYNTHESIS
  // Sampled on the falling edge so an asynchronous clear has settled before it is checked.
  always @(negedge Clock) begin
    if (!Clr) begin
      assert (Hout == RESET_VALUE);
    end
  end
`endif

endmodule

// File: tb/tb_registers.sv
// Directed bench for registers: reset, load/hold, async clear and back-to-back loads.
module tb_registers;

  logic       Clock;
  logic       Clr;
  logic       Enable;
  logic [7:0] H;
  logic [7:0] Hout;

  int n_cmp;
  int n_err;

  typedef struct {
    logic       clr;
    logic       en;
    logic [7:0] h;
    logic [7:0] exp;
    string      name;
  } vec_t;

  vec_t vecs[14];

  registers dut (
    .Clock  (Clock),
    .Clr    (Clr),
    .Enable (Enable),
    .H      (H),
    .Hout   (Hout)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: Hout=%02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic clr, input logic en, input logic [7:0] h);
    Clr    = clr;
    Enable = en;
    H      = h;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;

    vecs[0]  = '{1'b0, 1'b1, 8'h07, 8'h00, "clr_dominates_load"};
    vecs[1]  = '{1'b1, 1'b1, 8'h07, 8'h07, "first_load_after_release"};
    vecs[2]  = '{1'b1, 1'b0, 8'h07, 8'h07, "stays_07"};
    vecs[3]  = '{1'b1, 1'b1, 8'hA5, 8'hA5, "load_a5"};
    vecs[4]  = '{1'b1, 1'b0, 8'h3C, 8'hA5, "hold_a5_1"};
    vecs[5]  = '{1'b1, 1'b0, 8'h3C, 8'hA5, "hold_a5_2"};
    vecs[6]  = '{1'b1, 1'b0, 8'h3C, 8'hA5, "hold_a5_3"};
    vecs[7]  = '{1'b1, 1'b0, 8'h3C, 8'hA5, "hold_a5_4"};
    vecs[8]  = '{1'b1, 1'b0, 8'h3C, 8'hA5, "hold_a5_5"};
    vecs[9]  = '{1'b1, 1'b1, 8'h3C, 8'h3C, "load_3c"};
    vecs[10] = '{1'b1, 1'b1, 8'hFF, 8'hFF, "step_ff"};
    vecs[11] = '{1'b1, 1'b1, 8'h00, 8'h00, "step_00"};
    vecs[12] = '{1'b1, 1'b1, 8'h80, 8'h80, "step_80"};
    vecs[13] = '{1'b1, 1'b0, 8'h55, 8'h80, "hold_80"};

    // Power-up: clear held low for 100 ns.
    drive(1'b0, 1'b0, 8'h00);
    #1;
    check("reset_initial", Hout, 8'h00);
    for (int c = 0; c < 10; c++) begin
      @(posedge Clock);
      #1;
      check("reset_hold", Hout, 8'h00);
    end

    // Inputs change 3 ns after an edge, results sampled 1 ns after the next edge.
    for (int v = 0; v < 14; v++) begin
      #2;
      drive(vecs[v].clr, vecs[v].en, vecs[v].h);
      @(posedge Clock);
      #1;
      check(vecs[v].name, Hout, vecs[v].exp);
    end

    // No combinational path from H/Enable: mid-cycle change must not show before the edge.
    #2;
    drive(1'b1, 1'b1, 8'h5A);
    #2;
    check("no_comb_path", Hout, 8'h80);
    @(posedge Clock);
    #1;
    check("load_5a", Hout, 8'h5A);

    // Async clear between edges with a load pending.
    #2;
    drive(1'b0, 1'b1, 8'h08);
    #1;
    check("async_clear_immediate", Hout, 8'h00);
    for (int c = 0; c < 3; c++) begin
      @(posedge Clock);
      #1;
      check("clear_held", Hout, 8'h00);
    end

    // Release clear: nothing changes until the next rising edge, then the load happens.
    #2;
    drive(1'b1, 1'b1, 8'h08);
    #2;
    check("release_no_edge", Hout, 8'h00);
    @(posedge Clock);
    #1;
    check("load_after_release", Hout, 8'h08);

    // Clear asserted just before an edge discards that edge's load.
    #2;
    drive(1'b1, 1'b1, 8'hC3);
    @(posedge Clock);
    #1;
    check("load_c3", Hout, 8'hC3);
    #2;
    drive(1'b0, 1'b1, 8'h11);
    @(posedge Clock);
    #1;
    check("edge_during_clear", Hout, 8'h00);
    #2;
    drive(1'b1, 1'b1, 8'h11);
    @(posedge Clock);
    #1;
    check("load_11", Hout, 8'h11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
